// File: rtl/ps2_mouse_init_sequencer_pkg.sv
// Shared types and protocol byte values for the PS/2 mouse initialisation sequencer.
package ps2_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    NEXT,
    FAIL,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

endpackage

// File: rtl/ps2_mouse_init_sequencer_rom.sv
// Sequence table: for a step and response index, the command to send,
// the response byte expected and whether it closes the step.
module ps2_init_rom
  import ps2_init_pkg::*;
(
  input  logic       step,
  input  logic [1:0] resp_idx,
  output logic [7:0] command,
  output logic [7:0] expected,
  output logic       last
);

  always_comb begin
    command  = CMD_RESET;
    expected = RSP_ACK;
    last     = 1'b1;
    if (!step) begin
      // Reset answers with ACK, self-test passed, then the device ID.
      case (resp_idx)
        2'd0:    begin expected = RSP_ACK;    last = 1'b0; end
        2'd1:    begin expected = RSP_BAT_OK; last = 1'b0; end
        default: begin expected = RSP_ID;     last = 1'b1; end
      endcase
    end else begin
      command  = CMD_ENABLE;
      expected = RSP_ACK;
      last     = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// Drives the mouse reset / enable-reporting command sequence, checks every
// response byte and retries the whole sequence on any failure.
module ps2_mouse_init_sequencer
  import ps2_init_pkg::*;
#(
  parameter int RESP_TIMEOUT_CYCLES = 25_000_000,
  parameter int RESP_TIMEOUT_BITS   = 25,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       busy,
  output logic       init_done,
  output logic       init_error,
  output logic [1:0] retry_count
);

  localparam logic [RESP_TIMEOUT_BITS-1:0] TIMER_LIMIT = RESP_TIMEOUT_BITS'(RESP_TIMEOUT_CYCLES);
  localparam logic [RESP_TIMEOUT_BITS-1:0] TIMER_ONE   = RESP_TIMEOUT_BITS'(1);
  localparam logic [1:0]                   RETRY_LIMIT = 2'(MAX_RETRIES);

  state_t                       state_reg, state_next;
  logic                         step_reg, step_next;
  logic [1:0]                   resp_idx_reg, resp_idx_next;
  logic [RESP_TIMEOUT_BITS-1:0] timer_reg, timer_next;
  logic [1:0]                   retry_reg, retry_next;
  logic [7:0]                   cmd_reg, cmd_next;
  logic                         send_reg, send_next;
  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic                         error_reg, error_next;

  logic [7:0] rom_cmd  [2];
  logic [7:0] rom_exp  [2];
  logic       rom_last [2];

  // One table lookup per step so the next command is known before step changes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_step
    ps2_init_rom u_rom (
      .step     (1'(gi)),
      .resp_idx (resp_idx_reg),
      .command  (rom_cmd[gi]),
      .expected (rom_exp[gi]),
      .last     (rom_last[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      step_reg     <= 1'b0;
      resp_idx_reg <= 2'd0;
      timer_reg    <= '0;
      retry_reg    <= 2'd0;
      cmd_reg      <= 8'h00;
      send_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      resp_idx_reg <= resp_idx_next;
      timer_reg    <= timer_next;
      retry_reg    <= retry_next;
      cmd_reg      <= cmd_next;
      send_reg     <= send_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    resp_idx_next = resp_idx_reg;
    timer_next    = timer_reg;
    retry_next    = retry_reg;
    cmd_next      = cmd_reg;
    send_next     = 1'b0;
    done_next     = done_reg;
    error_next    = error_reg;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          retry_next = 2'd0;
          done_next  = 1'b0;
          error_next = 1'b0;
          step_next  = 1'b0;
          cmd_next   = rom_cmd[0];
          state_next = SEND;
        end
      end
      SEND: begin
        send_next = send_reg;
        if (send_reg) begin
          if (command_was_sent) begin
            send_next     = 1'b0;
            resp_idx_next = 2'd0;
            timer_next    = '0;
            state_next    = WAIT;
          end else if (error_communication_timed_out) begin
            send_next  = 1'b0;
            state_next = FAIL;
          end
        end else if (!command_was_sent && !error_communication_timed_out) begin
          // Only request once the command-out stage is back at rest.
          send_next = 1'b1;
        end
      end
      WAIT: begin
        if (received_data_en) begin
          if (received_data == rom_exp[step_reg]) begin
            if (rom_last[step_reg]) begin
              state_next = NEXT;
            end else begin
              resp_idx_next = resp_idx_reg + 2'd1;
              timer_next    = '0;
            end
          end else begin
            // Resend requests and unexpected bytes both restart the sequence.
            state_next = FAIL;
          end
        end else if (timer_reg == TIMER_LIMIT) begin
          state_next = FAIL;
        end else if (timer_reg != '1) begin
          timer_next = timer_reg + TIMER_ONE;
        end
      end
      NEXT: begin
        if (step_reg) begin
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          step_next  = 1'b1;
          cmd_next   = rom_cmd[1];
          state_next = SEND;
        end
      end
      FAIL: begin
        retry_next = retry_reg + 2'd1;
        if (retry_reg + 2'd1 == RETRY_LIMIT) begin
          error_next = 1'b1;
          state_next = ERROR;
        end else begin
          step_next  = 1'b0;
          cmd_next   = rom_cmd[0];
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = !(state_next inside {IDLE, DONE, ERROR});
  end

  assign the_command  = cmd_reg;
  assign send_command = send_reg;
  assign busy         = busy_reg;
  assign init_done    = done_reg;
  assign init_error   = error_reg;
  assign retry_count  = retry_reg;

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Directed self-checking bench for the PS/2 mouse initialisation sequencer.
module tb_ps2_mouse_init_sequencer;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       busy;
  logic       init_done;
  logic       init_error;
  logic [1:0] retry_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ps2_mouse_init_sequencer #(
    .RESP_TIMEOUT_CYCLES (TO),
    .RESP_TIMEOUT_BITS   (8),
    .MAX_RETRIES         (3)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .start                         (start),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .busy                          (busy),
    .init_done                     (init_done),
    .init_error                    (init_error),
    .retry_count                   (retry_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (send_command) ok = 1'b1;
      else tick();
    end
  endtask

  // Holds off the acknowledge for 'delay' cycles, noting whether the request stayed steady.
  task automatic ack_cmd(input int delay, output bit held);
    logic [7:0] c;
    c = the_command;
    held = 1'b1;
    repeat (delay) begin
      tick();
      if (!send_command || the_command !== c) held = 1'b0;
    end
    command_was_sent = 1'b1;
    tick();
    command_was_sent = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    received_data = b;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests_run++; if (the_command !== 8'h00) begin tests_failed++; $display("FAIL reset_command: got %h expected 00", the_command); end
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL reset_send: got %b expected 0", send_command); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", init_done); end
    tests_run++; if (init_error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b expected 0", init_error); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
    reset = 1'b1;
    repeat (3) tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_normal();
    bit ok, held;
    pulse_start();
    tests_run++; if (the_command !== 8'hFF) begin tests_failed++; $display("FAIL normal_cmd0: got %h expected FF", the_command); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL normal_busy: got %b expected 1", busy); end
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL normal_send_early: got %b expected 0", send_command); end
    wait_send(ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL normal_send0: got %b expected 1", ok); end
    ack_cmd(200, held);
    tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL normal_hold0: got %b expected 1", held); end
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL normal_send_drop: got %b expected 0", send_command); end
    strobe(8'hFA); strobe(8'hAA); strobe(8'h00);
    wait_send(ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL normal_send1: got %b expected 1", ok); end
    tests_run++; if (the_command !== 8'hF4) begin tests_failed++; $display("FAIL normal_cmd1: got %h expected F4", the_command); end
    ack_cmd(200, held);
    strobe(8'hFA);
    tick(); tick();
    tests_run++; if (init_done !== 1'b1) begin tests_failed++; $display("FAIL normal_done: got %b expected 1", init_done); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL normal_retry: got %0d expected 0", retry_count); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL normal_busy_end: got %b expected 0", busy); end
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL normal_send_end: got %b expected 0", send_command); end
    $display("[TB] test_normal complete");
  endtask

  task automatic test_mismatch();
    bit ok, held;
    pulse_start();
    tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL mismatch_done_clear: got %b expected 0", init_done); end
    wait_send(ok);
    ack_cmd(5, held);
    strobe(8'hFA); strobe(8'hFC);
    tick();
    tests_run++; if (retry_count !== 2'd1) begin tests_failed++; $display("FAIL mismatch_retry: got %0d expected 1", retry_count); end
    tests_run++; if (the_command !== 8'hFF) begin tests_failed++; $display("FAIL mismatch_resend_cmd: got %h expected FF", the_command); end
    wait_send(ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL mismatch_resend: got %b expected 1", ok); end
    ack_cmd(5, held);
    strobe(8'hFA); strobe(8'hAA); strobe(8'h00);
    wait_send(ok);
    ack_cmd(5, held);
    strobe(8'hFA);
    tick(); tick();
    tests_run++; if (init_done !== 1'b1) begin tests_failed++; $display("FAIL mismatch_done: got %b expected 1", init_done); end
    tests_run++; if (retry_count !== 2'd1) begin tests_failed++; $display("FAIL mismatch_retry_end: got %0d expected 1", retry_count); end
    $display("[TB] test_mismatch complete");
  endtask

  task automatic test_ignored_and_coincident();
    bit ok, held;
    pulse_start();
    strobe(8'hFC);
    wait_send(ok);
    strobe(8'hFA);
    ack_cmd(5, held);
    tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL ignored_hold: got %b expected 1", held); end
    strobe(8'hFA); strobe(8'hAA); strobe(8'h00);
    wait_send(ok);
    ack_cmd(5, held);
    repeat (TO) tick();
    strobe(8'hFA);
    tick(); tick();
    tests_run++; if (init_done !== 1'b1) begin tests_failed++; $display("FAIL coincident_done: got %b expected 1", init_done); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL coincident_retry: got %0d expected 0", retry_count); end
    $display("[TB] test_ignored_and_coincident complete");
  endtask

  task automatic test_timeout();
    bit ok, held;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_send(ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL timeout_send%0d: got %b expected 1", i, ok); end
      ack_cmd(3, held);
      repeat (TO) tick();
      tests_run++; if (retry_count !== 2'(i)) begin tests_failed++; $display("FAIL timeout_early%0d: got %0d expected %0d", i, retry_count, i); end
      tick(); tick();
      tests_run++; if (retry_count !== 2'(i + 1)) begin tests_failed++; $display("FAIL timeout_retry%0d: got %0d expected %0d", i, retry_count, i + 1); end
    end
    tests_run++; if (init_error !== 1'b1) begin tests_failed++; $display("FAIL timeout_error: got %b expected 1", init_error); end
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL timeout_send_end: got %b expected 0", send_command); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL timeout_done: got %b expected 0", init_done); end
    $display("[TB] test_timeout complete");
  endtask

  task automatic test_txerror();
    bit ok, reasserted;
    pulse_start();
    tests_run++; if (init_error !== 1'b0) begin tests_failed++; $display("FAIL txerr_error_clear: got %b expected 0", init_error); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL txerr_retry_clear: got %0d expected 0", retry_count); end
    wait_send(ok);
    error_communication_timed_out = 1'b1;
    tick();
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL txerr_drop: got %b expected 0", send_command); end
    tick();
    tests_run++; if (retry_count !== 2'd1) begin tests_failed++; $display("FAIL txerr_retry: got %0d expected 1", retry_count); end
    reasserted = 1'b0;
    repeat (10) begin
      tick();
      if (send_command) reasserted = 1'b1;
    end
    tests_run++; if (reasserted !== 1'b0) begin tests_failed++; $display("FAIL txerr_hold_low: got %b expected 0", reasserted); end
    error_communication_timed_out = 1'b0;
    wait_send(ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL txerr_resume: got %b expected 1", ok); end
    tests_run++; if (the_command !== 8'hFF) begin tests_failed++; $display("FAIL txerr_cmd: got %h expected FF", the_command); end
    $display("[TB] test_txerror complete");
  endtask

  task automatic test_reset_mid();
    bit ok, held;
    ack_cmd(5, held);
    strobe(8'hFA); strobe(8'hAA); strobe(8'h00);
    wait_send(ok);
    tests_run++; if (the_command !== 8'hF4) begin tests_failed++; $display("FAIL rstmid_cmd1: got %h expected F4", the_command); end
    ack_cmd(5, held);
    reset = 1'b0;
    #2;
    tests_run++; if (the_command !== 8'h00) begin tests_failed++; $display("FAIL rstmid_command: got %h expected 00", the_command); end
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL rstmid_send: got %b expected 0", send_command); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tests_run++; if (retry_count !== 2'd0) begin tests_failed++; $display("FAIL rstmid_retry: got %0d expected 0", retry_count); end
    tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done: got %b expected 0", init_done); end
    tests_run++; if (init_error !== 1'b0) begin tests_failed++; $display("FAIL rstmid_error: got %b expected 0", init_error); end
    reset = 1'b1;
    repeat (10) tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_idle_busy: got %b expected 0", busy); end
    tests_run++; if (send_command !== 1'b0) begin tests_failed++; $display("FAIL rstmid_idle_send: got %b expected 0", send_command); end
    $display("[TB] test_reset_mid complete");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_mismatch();
    test_ignored_and_coincident();
    test_timeout();
    test_txerror();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_init_sequencer.md
# ps2_mouse_init_sequencer

Upstream controller for the PS/2 command-out stage.
- Drives `the_command`/`send_command` with a fixed mouse initialisation sequence: reset (0xFF), then enable data reporting (0xF4).
- Checks each device response byte delivered by the PS/2 receive path.
- Retries the whole sequence on timeout, mismatch or transmit error, up to a retry limit.
- Reports `init_done` or `init_error` to the game logic.

## Interface
Parameters:
- RESP_TIMEOUT_CYCLES, 25_000_000 — maximum clk cycles to wait for each response byte (500 ms at 50 MHz).
- RESP_TIMEOUT_BITS, 25 — width of the response timeout counter.
- MAX_RETRIES, 3 — number of failed attempts allowed before `init_error`.

Ports (clock and reset first):
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset; one clock domain.
- start  in  1  level; when high in IDLE, DONE or ERROR, the sequence (re)starts.
- the_command  out  8  command byte to the command-out stage.
- send_command  out  1  request to the command-out stage; held high until that stage acknowledges.
- command_was_sent  in  1  acknowledge from the command-out stage.
- error_communication_timed_out  in  1  transmit error from the command-out stage.
- received_data  in  8  byte from the PS/2 receiver.
- received_data_en  in  1  one-cycle strobe; `received_data` is valid in that cycle.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- init_done  out  1  sticky; set on successful completion.
- init_error  out  1  sticky; set when retries are exhausted.
- retry_count  out  2  number of failed attempts in the current run.

## Operation
Sequence, stored as steps:
- step 0: send 0xFF; expect 0xFA, 0xAA, 0x00.
- step 1: send 0xF4; expect 0xFA.

States:
- IDLE: `start`=1 → clear `retry_count`, `init_done`, `init_error`; step=0; go to SEND.
- SEND: `the_command`=cmd[step].
  - `send_command` rises only when `command_was_sent`=0 and `error_communication_timed_out`=0. This guarantees the command-out stage has returned to idle.
  - `command_was_sent`=1 → drop `send_command`; resp_idx=0; clear timer; go to WAIT.
  - `error_communication_timed_out`=1 → drop `send_command`; go to FAIL.
- WAIT: the timer counts every cycle.
  - Strobe with byte == expected[step][resp_idx]:
    - if it was the last expected byte of the step: go to NEXT;
    - otherwise resp_idx++ and clear the timer.
  - Strobe with 0xFE (resend): go to FAIL.
  - Strobe with any other byte: go to FAIL.
  - Timer == RESP_TIMEOUT_CYCLES: go to FAIL.
- NEXT: if step==1, go to DONE and set `init_done`; otherwise step++ and go to SEND.
- FAIL: `retry_count`++.
  - If the new count == MAX_RETRIES: go to ERROR and set `init_error`.
  - Otherwise step=0; go to SEND (full restart from 0xFF).
- DONE / ERROR: hold the sticky flag. `start`=1 → behave as in IDLE.

Other rules:
- Strobes received outside WAIT are ignored.
- A strobe in the same cycle as timer expiry: the strobe wins.
- Reset asserted mid-sequence: everything returns immediately to IDLE and outputs to reset values. The command-out stage sees `send_command`=0 and aborts.

## Timing
- All outputs are registered.
- Reset values:
  - `the_command`=0x00
  - `send_command`=0
  - `busy`=0
  - `init_done`=0
  - `init_error`=0
  - `retry_count`=0
- IDLE→SEND takes 1 cycle after `start`. `send_command` is high no earlier than the cycle after entering SEND.
- `the_command` is stable for the whole time `send_command` is high. It is loaded on entry to SEND.
- `send_command` falls in the cycle after `command_was_sent` or the error input is sampled high.
- Timer width is RESP_TIMEOUT_BITS. It is compared for equality and saturates; it never wraps.
- `retry_count` never exceeds MAX_RETRIES.

## Structure
- Package `ps2_init_pkg`:
  - state enum: IDLE, SEND, WAIT, NEXT, FAIL, DONE, ERROR;
  - command constants: CMD_RESET=0xFF, CMD_ENABLE=0xF4;
  - response constants: RSP_ACK=0xFA, RSP_BAT_OK=0xAA, RSP_ID=0x00, RSP_RESEND=0xFE.
- One sub-module, `ps2_init_rom` (combinational): step, resp_idx → command, expected byte, last-byte flag.

## Test plan
- Normal run: `start`, acknowledge each command after 200 cycles, supply FA, AA, 00, then FA → `the_command` is FF then F4; `init_done`=1, `retry_count`=0, `busy`=0.
- Mismatch: after FF, supply FA, FC → FAIL; `retry_count`=1; FF is resent. A subsequent clean run ends with `init_done`=1, `retry_count`=1.
- Timeout with RESP_TIMEOUT_CYCLES=100: no response after FF → FAIL on cycle 100. Three consecutive failures → `init_error`=1, `retry_count`=3, `send_command`=0.
- Transmit error: assert `error_communication_timed_out` during SEND → `send_command` drops next cycle; `retry_count`=1. While the error input remains high, `send_command` is not reasserted.
- Reset mid-WAIT (step 1) → all outputs return to reset values immediately. With `start` held low, the block stays in IDLE.
- A strobe outside WAIT (during SEND) is ignored. A strobe coincident with timer expiry and carrying the correct byte is accepted.
